triangle_generator: RTL
=======================

# triangle_generator

Programmable triangle-wave stream source. It drives an AXI4-Stream master port with a signed ramp that rises from a low limit to a high limit and falls back, repeating indefinitely. It sits on the opposite end of the stream interface from the extremum finder. Its purpose is to give that block, and other sample consumers, a deterministic excitation with known extrema and a known period.

## Interface
- AXIS_TDATA_WIDTH, 32, sample width; samples are signed two's complement.
- SYS_aclk  in  1  clock, all logic on the rising edge.
- SYS_aresetn  in  1  asynchronous, active-low reset.
- TG_enable  in  1  run request; level-sensitive.
- TG_low  in  AXIS_TDATA_WIDTH  lower turning point, signed.
- TG_high  in  AXIS_TDATA_WIDTH  upper turning point, signed.
- TG_step  in  16  unsigned increment per sample.
- TG_log_hold  in  5  each sample is repeated 2^TG_log_hold beats.
- M_AXIS_tdata  out  AXIS_TDATA_WIDTH  current sample.
- M_AXIS_tvalid  out  1  sample valid.
- M_AXIS_tready  in  1  consumer ready.
- M_AXIS_tlast  out  1  marks the final beat of a turning-point sample.
- TG_period_count  out  16  completed full periods; wraps modulo 2^16.

## Operation
- A beat is a cycle with M_AXIS_tvalid && M_AXIS_tready.
- State machine has three states: IDLE, UP, DOWN.
- **IDLE**
  - Config is valid iff TG_low < TG_high (signed) and TG_step != 0.
  - With TG_enable=1 and a valid config, the block latches TG_low, TG_high, TG_step and TG_log_hold.
  - It then loads value=TG_low, clears the hold counter and enters UP.
  - Invalid config, or TG_enable=0, keeps the block in IDLE with tvalid=0.
- Config inputs are ignored outside IDLE. Changes take effect only after returning to IDLE.
- **Hold counter**
  - Counts beats, 0 to 2^log_hold-1.
  - The value advances only on the beat where the counter is terminal; the counter then returns to 0.
  - With log_hold=0, every beat is terminal.
- **UP advance**
  - next = value + step, computed in AXIS_TDATA_WIDTH+1 bits (no wrap).
  - If next >= high: value=high and state becomes DOWN. Otherwise value=next.
- **DOWN advance**
  - next = value - step, computed in AXIS_TDATA_WIDTH+1 bits.
  - If next <= low: value=low, state becomes UP, and TG_period_count increments.
  - Otherwise value=next.
- **Turning points**
  - Turning points are always emitted exactly, even when step does not divide (high-low).
  - The initial TG_low emission after leaving IDLE does not count as a period.
- **tlast** = 1 on the terminal hold beat of any sample equal to the latched high or latched low. This includes the first low after start.
- **Disable**
  - TG_enable is evaluated only on beats.
  - A beat with TG_enable=0 completes normally. The block then enters IDLE and drops tvalid.
  - A pending, unaccepted sample is never withdrawn.
- **AXI stability**: while tvalid=1 and tready=0, tdata and tlast hold stable.

## Timing
- All outputs are registered.
- **Reset values**: M_AXIS_tdata=0, M_AXIS_tvalid=0, M_AXIS_tlast=0, TG_period_count=0, state IDLE, hold counter 0.
- **Start latency**: TG_enable=1 with valid config sampled at edge k gives tvalid=1, tdata=TG_low at edge k+1.
- **Throughput**: one beat per cycle while tready=1. A beat at edge k presents the next sample at edge k+1.
- **Stop**: a beat with TG_enable=0 at edge k gives tvalid=0 at edge k+1.
- **Restart**: from IDLE, a new start takes one cycle after tvalid dropped.
- **Period update**: TG_period_count updates on the same edge that loads value=low in DOWN, i.e. together with the low sample appearing on tdata.
- **Async reset mid-stream**: all outputs go to reset values immediately, with no partial beat. Operation resumes only via IDLE start.
- **Counter wrap**: TG_period_count wraps 0xFFFF→0x0000 silently.

## Test plan
- **Basic ramp**: low=-40, high=60, step=20, log_hold=0, tready=1, enable=1.
  - tdata = -40(tlast), -20, 0, 20, 40, 60(tlast), 40, 20, 0, -20, -40(tlast), -20, …
  - TG_period_count goes 0→1 with the second -40.
- **Clamping**: low=-10, high=25, step=20.
  - tdata = -10(tlast), 10, 25(tlast), 5, -10(tlast), 10.
- **Backpressure**: during the basic ramp, drop tready for 5 cycles while tdata=20.
  - tdata stays 20 and tvalid stays 1 throughout.
  - 40 follows the first beat after tready returns.
- **Hold**: log_hold=2, low=0, high=10, step=10.
  - Each value appears for 4 beats.
  - tlast appears only on the 4th beat of 0 and of 10.
- **Invalid config and disable**
  - high=low=5: tvalid stays 0 for 20 cycles.
  - Then high=15, step=5: -> 5,10,15.
  - Deassert enable with tready=0 at 10: 10 is held until tready=1, then tvalid=0 the next cycle.
- **Extremes and reset**: low=-2^31, high=2^31-1, step=0xFFFF.
  - The rise saturates exactly at 0x7FFFFFFF with tlast; no wrap to negative.
  - Assert SYS_aresetn=0 mid-ramp: tvalid, tdata and TG_period_count are 0 immediately.

Source files
------------

// File: rtl/triangle_generator.sv
// triangle_generator
//   AXI4-Stream master producing a signed triangle ramp between a latched low
//   and high turning point. Each sample is held for 2^log_hold beats; tlast
//   marks the final beat of every turning-point sample. Configuration is
//   latched on leaving IDLE and ignored while running.
//
// Ports
//   SYS_aclk         clock, rising edge
//   SYS_aresetn      asynchronous active-low reset
//   TG_enable        run request (sampled in IDLE and on every beat)
//   TG_low/TG_high   signed turning points (low < high required)
//   TG_step          unsigned increment per sample (non-zero required)
//   TG_log_hold      log2 of beats per sample
//   M_AXIS_tdata     current sample
//   M_AXIS_tvalid    sample valid
//   M_AXIS_tready    consumer ready
//   M_AXIS_tlast     last beat of a turning-point sample
//   TG_period_count  completed full periods, wraps modulo 2^16
module triangle_generator #(
   parameter int AXIS_TDATA_WIDTH = 32
) (
   input  logic                        SYS_aclk,
   input  logic                        SYS_aresetn,
   input  logic                        TG_enable,
   input  logic [AXIS_TDATA_WIDTH-1:0] TG_low,
   input  logic [AXIS_TDATA_WIDTH-1:0] TG_high,
   input  logic [15:0]                 TG_step,
   input  logic [4:0]                  TG_log_hold,
   output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
   output logic                        M_AXIS_tvalid,
   input  logic                        M_AXIS_tready,
   output logic                        M_AXIS_tlast,
   output logic [15:0]                 TG_period_count
);

   localparam int W = AXIS_TDATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      UP,
      DOWN
   } state_t;

   state_t          state, state_nx;
   logic [W-1:0]    low_q, low_nx, high_q, high_nx;
   logic [15:0]     step_q, step_nx;
   logic [4:0]      log_q, log_nx;
   logic [31:0]     hold_q, hold_nx;
   logic [W-1:0]    data_nx;
   logic            valid_nx, last_nx;
   logic [15:0]     period_nx;

   logic            beat, cfg_ok, terminal, turning;
   logic [31:0]     hold_max;
   logic signed [W:0] sum_up, sum_dn, low_x, high_x;

   assign beat     = M_AXIS_tvalid && M_AXIS_tready;
   assign cfg_ok   = ($signed(TG_low) < $signed(TG_high)) && (TG_step != 16'd0);
   assign hold_max = ~({32{1'b1}} << log_q);
   assign terminal = (hold_q == hold_max);
   assign turning  = (M_AXIS_tdata == low_q) || (M_AXIS_tdata == high_q);

   // One extra bit so the ramp can overshoot the limits without wrapping
   // before it is clamped to the turning point.
   assign sum_up = $signed({M_AXIS_tdata[W-1], M_AXIS_tdata}) + $signed({{(W-15){1'b0}}, step_q});
   assign sum_dn = $signed({M_AXIS_tdata[W-1], M_AXIS_tdata}) - $signed({{(W-15){1'b0}}, step_q});
   assign low_x  = $signed({low_q[W-1], low_q});
   assign high_x = $signed({high_q[W-1], high_q});

   always_comb begin
      state_nx  = state;
      low_nx    = low_q;
      high_nx   = high_q;
      step_nx   = step_q;
      log_nx    = log_q;
      hold_nx   = hold_q;
      data_nx   = M_AXIS_tdata;
      valid_nx  = M_AXIS_tvalid;
      last_nx   = M_AXIS_tlast;
      period_nx = TG_period_count;

      case (state)
         IDLE: begin
            valid_nx = 1'b0;
            last_nx  = 1'b0;
            if (TG_enable && cfg_ok) begin
               low_nx   = TG_low;
               high_nx  = TG_high;
               step_nx  = TG_step;
               log_nx   = TG_log_hold;
               data_nx  = TG_low;
               hold_nx  = '0;
               valid_nx = 1'b1;
               last_nx  = (TG_log_hold == 5'd0);
               state_nx = UP;
            end
         end
         UP, DOWN: begin
            if (beat) begin
               if (!TG_enable) begin
                  // The accepted beat completes; nothing new is presented.
                  valid_nx = 1'b0;
                  last_nx  = 1'b0;
                  hold_nx  = '0;
                  state_nx = IDLE;
               end else if (terminal) begin
                  hold_nx = '0;
                  if (state == UP) begin
                     if (sum_up >= high_x) begin
                        data_nx  = high_q;
                        state_nx = DOWN;
                     end else begin
                        data_nx = sum_up[W-1:0];
                     end
                  end else begin
                     if (sum_dn <= low_x) begin
                        data_nx   = low_q;
                        state_nx  = UP;
                        period_nx = TG_period_count + 16'd1;
                     end else begin
                        data_nx = sum_dn[W-1:0];
                     end
                  end
                  // A fresh sample's first beat is terminal only when unheld.
                  last_nx = (log_q == 5'd0) && ((data_nx == low_q) || (data_nx == high_q));
               end else begin
                  hold_nx = hold_q + 32'd1;
                  last_nx = turning && ((hold_q + 32'd1) == hold_max);
               end
            end
         end
         default: begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            last_nx  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
      if (!SYS_aresetn) begin
         state           <= IDLE;
         low_q           <= '0;
         high_q          <= '0;
         step_q          <= '0;
         log_q           <= '0;
         hold_q          <= '0;
         M_AXIS_tdata    <= '0;
         M_AXIS_tvalid   <= 1'b0;
         M_AXIS_tlast    <= 1'b0;
         TG_period_count <= '0;
      end else begin
         state           <= state_nx;
         low_q           <= low_nx;
         high_q          <= high_nx;
         step_q          <= step_nx;
         log_q           <= log_nx;
         hold_q          <= hold_nx;
         M_AXIS_tdata    <= data_nx;
         M_AXIS_tvalid   <= valid_nx;
         M_AXIS_tlast    <= last_nx;
         TG_period_count <= period_nx;
      end
   end

endmodule
